// File: rtl/morse_uart_tx.sv
// UART 8N1 transmitter for decoded Morse characters, fed through a small FIFO.
// The FIFO is popped straight into the shift register; tx is registered one cycle behind the FSM.
`timescale 1ns/1ps
module morse_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    char_in,
   input  logic                          char_valid,
   output logic                          tx,
   output logic                          busy,
   output logic                          fifo_full,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   logic          full, push, pop, bit_done;

   assign full     = (count_q == DEPTH);
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push     = char_valid && (!full || pop);
   assign bit_done = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      tx_d    = 1'b1;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (bit_done) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            tx_d = shift_q[idx_q];
            if (bit_done) begin
               cnt_d = '0;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (bit_done) begin
               cnt_d = '0;
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is not reset; emptying the pointers discards its contents.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= char_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= 3'd0;
         shift_q    <= 8'h00;
         tx_q       <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         if (char_valid && full && !pop) overflow_q <= 1'b1;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign tx         = tx_q;
   assign busy       = (state_q != IDLE) || (count_q != '0);
   assign fifo_full  = full;
   assign overflow   = overflow_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_morse_uart_tx.sv
// Directed bench for morse_uart_tx: a sampling UART receiver recovers frames on tx,
// and each scenario task compares against hand-computed bytes, latencies and flags.
`timescale 1ns/1ps
module tb_morse_uart_tx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] char_in = 8'h00;
   logic       char_valid = 1'b0;
   logic       tx, busy, fifo_full, overflow;
   logic [2:0] fifo_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   morse_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .char_valid (char_valid),
      .tx         (tx),
      .busy       (busy),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .fifo_count (fifo_count)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time exceeded, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   // Waits (bounded) for a start bit, then samples mid-bit. Called and returns at a negedge.
   task automatic uart_rx(output logic [7:0] data, output logic start_ok, output logic stop_ok,
                          output int wait_cyc, output logic timeout);
      data = 8'h00; start_ok = 1'b0; stop_ok = 1'b0; timeout = 1'b1; wait_cyc = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         wait_cyc++;
         if (tx === 1'b0) begin
            timeout = 1'b0;
            break;
         end
      end
      if (!timeout) begin
         repeat (CPB / 2) @(negedge clk);
         start_ok = (tx === 1'b0);
         for (int b = 0; b < 8; b++) begin
            repeat (CPB) @(negedge clk);
            data[b] = tx;
         end
         repeat (CPB) @(negedge clk);
         stop_ok = (tx === 1'b1);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      rst = 1'b0;
      $display("reset: tx=%b busy=%b count=%0d", tx, busy, fifo_count);
   endtask

   task automatic test_idle();
      int bad;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad); end
      $display("idle: 1000 cycles, bad=%0d", bad);
   endtask

   task automatic test_single_char();
      logic [7:0] d; logic s_ok, p_ok, to; int w;
      char_in = 8'h53; char_valid = 1'b1;
      @(negedge clk);
      char_valid = 1'b0;
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
      uart_rx(d, s_ok, p_ok, w, to);
      $display("single: rx byte=%02h wait=%0d start=%b stop=%b", d, w, s_ok, p_ok);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b expected 0", to); end
      checks++; if (w !== 2) begin errors++; $display("FAIL single_latency: got %0d expected 2", w); end
      checks++; if (d !== 8'h53) begin errors++; $display("FAIL single_data: got %02h expected 53", d); end
      checks++; if ({s_ok, p_ok} !== 2'b11) begin errors++; $display("FAIL single_framing: got %b expected 11", {s_ok, p_ok}); end
      repeat (6) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b expected 1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d; logic s_ok, p_ok, to; int w;
      char_in = 8'h45; char_valid = 1'b1;
      @(negedge clk);
      char_in = 8'h54;
      @(negedge clk);
      char_valid = 1'b0;
      uart_rx(d, s_ok, p_ok, w, to);
      $display("b2b: rx byte=%02h wait=%0d", d, w);
      checks++; if (d !== 8'h45 || to !== 1'b0) begin errors++; $display("FAIL b2b_first: got %02h to=%b expected 45", d, to); end
      uart_rx(d, s_ok, p_ok, w, to);
      $display("b2b: rx byte=%02h wait=%0d", d, w);
      checks++; if (d !== 8'h54 || to !== 1'b0) begin errors++; $display("FAIL b2b_second: got %02h to=%b expected 54", d, to); end
      checks++; if (w !== CPB / 2) begin errors++; $display("FAIL b2b_gap: got %0d expected %0d", w, CPB / 2); end
      repeat (6) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_last: got %b expected 1", busy); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_overflow();
      logic [7:0] d; logic s_ok, p_ok, to; int w;
      for (int i = 0; i < 6; i++) begin
         char_in = 8'h41 + 8'(i); char_valid = 1'b1;
         @(negedge clk);
      end
      char_valid = 1'b0;
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", fifo_full); end
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      for (int i = 0; i < 5; i++) begin
         uart_rx(d, s_ok, p_ok, w, to);
         $display("ovf: rx byte=%02h", d);
         checks++;
         if (d !== 8'h41 + 8'(i) || to !== 1'b0 || {s_ok, p_ok} !== 2'b11) begin
            errors++; $display("FAIL ovf_data%0d: got %02h to=%b expected %02h", i, d, to, 8'h41 + 8'(i));
         end
      end
      uart_rx(d, s_ok, p_ok, w, to);
      checks++; if (to !== 1'b1) begin errors++; $display("FAIL ovf_no_sixth: got frame %02h expected none", d); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
   endtask

   task automatic test_full_pop();
      logic [7:0] d; logic s_ok, p_ok, to; int w;
      logic [7:0] exp_q [5];
      exp_q[0] = 8'h62; exp_q[1] = 8'h63; exp_q[2] = 8'h64; exp_q[3] = 8'h65; exp_q[4] = 8'h5A;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         char_in = 8'h61 + 8'(i); char_valid = 1'b1;
         @(negedge clk);
      end
      char_valid = 1'b0;
      // Move to the cycle in which the first frame's last STOP cycle is registered.
      repeat (10 * CPB - 4) @(negedge clk);
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_pre_count: got %0d expected 4", fifo_count); end
      char_in = 8'h5A; char_valid = 1'b1;
      @(negedge clk);
      char_valid = 1'b0;
      checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL fullpop_count: got %0d expected 4", fifo_count); end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fullpop_full: got %b expected 1", fifo_full); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow: got %b expected 0", overflow); end
      for (int i = 0; i < 5; i++) begin
         uart_rx(d, s_ok, p_ok, w, to);
         $display("fullpop: rx byte=%02h", d);
         checks++;
         if (d !== exp_q[i] || to !== 1'b0) begin
            errors++; $display("FAIL fullpop_data%0d: got %02h to=%b expected %02h", i, d, to, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d; logic s_ok, p_ok, to; int w;
      do_reset();
      repeat (40) @(negedge clk);
      char_in = 8'h55; char_valid = 1'b1;
      @(negedge clk);
      char_in = 8'h33;
      @(negedge clk);
      char_valid = 1'b0;
      // Middle of data bit 3 (0x55 bit 3 = 0).
      repeat (8 + 4 * CPB - 1) @(negedge clk);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rstmid_bit3: got %b expected 0", tx); end
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 1", fifo_count); end
      rst = 1'b1;
      #1;
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
      checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", fifo_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      char_in = 8'h4B; char_valid = 1'b1;
      @(negedge clk);
      char_valid = 1'b0;
      uart_rx(d, s_ok, p_ok, w, to);
      $display("rstmid: rx byte=%02h wait=%0d", d, w);
      checks++; if (w !== 2 || to !== 1'b0) begin errors++; $display("FAIL rstmid_latency: got %0d to=%b expected 2", w, to); end
      checks++; if (d !== 8'h4B) begin errors++; $display("FAIL rstmid_data: got %02h expected 4B", d); end
      uart_rx(d, s_ok, p_ok, w, to);
      checks++; if (to !== 1'b1) begin errors++; $display("FAIL rstmid_discard: got frame %02h expected none", d); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b expected 0", busy); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_char();
      repeat (5) @(negedge clk);
      test_back_to_back();
      repeat (5) @(negedge clk);
      test_overflow();
      test_full_pop();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/morse_uart_tx.md
MORSE_UART_TX -- requirements
Module: morse_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per UART bit period; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: character FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 char_in  input  8  decoded character byte from the Morse decode path (the top-level sout).
REQ-006 char_valid  input  1  one-cycle strobe; char_in is valid in that cycle.
REQ-007 tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-008 busy  output  1  high while a frame is being shifted out or the FIFO is non-empty.
REQ-009 fifo_full  output  1  high when the FIFO holds FIFO_DEPTH entries.
REQ-010 overflow  output  1  sticky flag: a char_valid arrived while the FIFO was full; cleared only by rst.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of FIFO entries currently occupied.

Function
REQ-012 The block SHALL write char_in into the FIFO on every cycle where char_valid=1 and the FIFO is not full.
REQ-013 The block SHALL discard a char_valid strobe that arrives while the FIFO is full, leave the FIFO unchanged, and set overflow.
REQ-014 Transmitter FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: tx=1; when the FIFO is non-empty, pop the head entry into the shift register and enter START on the next cycle.
REQ-016 START: tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-017 DATA: tx=shift[index] for CLKS_PER_BIT cycles per bit, indices 0..7; after bit 7, enter STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-019 If the FIFO is non-empty on the last STOP cycle, the FSM SHALL pop the next entry and enter START directly, with no idle gap between frames.
REQ-020 A frame SHALL last exactly 10*CLKS_PER_BIT cycles, measured from the first START cycle to the end of STOP.
REQ-021 First-frame latency SHALL be 2 cycles: char_valid sampled at edge N writes the FIFO, edge N+1 pops it, and tx falls after edge N+2.
REQ-022 A simultaneous push and pop in the same cycle SHALL both take effect and leave fifo_count unchanged; this includes the full case, because the pop frees the slot.
REQ-023 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-024 The bit-period counter SHALL count from 0 to CLKS_PER_BIT-1 and wrap to 0 at each bit boundary.
REQ-025 tx SHALL be driven from a register, so it is glitch-free.
REQ-026 fifo_full and fifo_count SHALL reflect registered FIFO state, updated on the same edge as the push or pop.
REQ-027 busy SHALL be 0 only in IDLE with fifo_count=0.

Reset
REQ-028 While rst=1, the block SHALL force tx=1, busy=0, fifo_full=0, overflow=0, fifo_count=0, FSM=IDLE, both pointers to 0, and the bit counter to 0.
REQ-029 Assertion of rst mid-frame SHALL abort the frame immediately and drive tx high asynchronously; FIFO contents SHALL be discarded.
REQ-030 After rst deasserts, the block SHALL accept char_valid on the first rising edge.

Verification
REQ-031 Single char, CLKS_PER_BIT=16: char_in=0x53 ('S') strobed once -> tx shows 0, 1,1,0,0,1,0,1,0, 1, each bit 16 cycles; frame = 160 cycles; busy returns to 0 afterwards.
REQ-032 Back-to-back chars: 'E' (0x45) then 'T' (0x54) strobed on consecutive cycles -> two frames with no idle gap; total high-to-idle duration 320 cycles.
REQ-033 Overflow: 6 strobes (0x41..0x46) on consecutive cycles while idle, FIFO_DEPTH=4 -> the 1st is popped, the 2nd..5th fill the FIFO, the 6th is dropped; overflow=1; output sequence is 0x41..0x45.
REQ-034 Full with simultaneous pop: FIFO full and a strobe on the cycle STOP ends -> the char is accepted, no overflow, fifo_count stays 4.
REQ-035 Reset mid-frame: rst pulsed during DATA bit 3 of 0x55 -> tx=1 within the same cycle; fifo_count=0; the next strobed 0x4B transmits correctly.
REQ-036 Idle check: no strobes for 1000 cycles after reset -> tx=1 and busy=0 throughout.
